vending_machine_gen: RTL and testbench

- Parametrised successor to the single-price rupee vending FSM.
- Accepts ₹1/₹2/₹5 coins and accumulates credit in a binary counter rather than one state per rupee.
- Vends at a configurable PRICE using a dispense/acknowledge handshake, with timeout-driven refund on a failed vend.
- Adds a cancel input and pays change or refunds serially, one coin per cycle, gated by a coin-hopper ready signal.

---
 rtl/vending_pkg.sv | 46 ++++
 rtl/vending_change_payout.sv | 44 ++++
 rtl/vending_machine_gen.sv | 154 +++++++++++++++
 tb/tb_vending_machine_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the parametrised rupee vending machine:
// state encodings, coin values and the coin-input decoder.
package vending_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_VEND    = 3'd2;
  localparam logic [2:0] ST_CHANGE  = 3'd3;
  localparam logic [2:0] ST_REFUND  = 3'd4;

  localparam logic [2:0] COIN_ONE  = 3'd1;
  localparam logic [2:0] COIN_TWO  = 3'd2;
  localparam logic [2:0] COIN_FIVE = 3'd5;

  // present: any coin line high; reject: coin seen but not creditable;
  // value: rupees to credit (0 when nothing is creditable).
  typedef struct packed {
    logic       present;
    logic       reject;
    logic [2:0] value;
  } coin_t;

  // Decode the three coin lines. Two or more simultaneous coins are
  // rejected as a group, as is a five when five-rupee coins are disabled.
  function automatic coin_t coin_decode(input logic one, input logic two,
                                        input logic five, input logic five_en);
    coin_t      c;
    logic [1:0] n;
    n         = 2'(one) + 2'(two) + 2'(five);
    c.present = (n != 2'd0);
    c.reject  = 1'b0;
    c.value   = 3'd0;
    if (n > 2'd1) begin
      c.reject = 1'b1;
    end else if (one) begin
      c.value = COIN_ONE;
    end else if (two) begin
      c.value = COIN_TWO;
    end else if (five) begin
      if (five_en) c.value  = COIN_FIVE;
      else         c.reject = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/vending_change_payout.sv
// Serial coin payout engine shared by change-giving and refunds.
// Load a rupee amount, then it issues one coin per hopper-ready cycle,
// preferring two-rupee coins, until nothing remains.
module vending_change_payout #(
  parameter int CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_value,
  input  logic                change_ready,
  output logic                return_one_rupee,
  output logic                return_two_rupee,
  output logic [CREDIT_W-1:0] remaining,
  output logic                done
);

  // Load a new amount or pay out one coin when the hopper is ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining        <= '0;
      return_one_rupee <= 1'b0;
      return_two_rupee <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values; the pulse defaults below are
      // overridden later in the same block without creating a race.
      return_one_rupee <= 1'b0;
      return_two_rupee <= 1'b0;
      if (load) begin
        remaining <= load_value;
      end else if (change_ready && remaining >= CREDIT_W'(2)) begin
        return_two_rupee <= 1'b1;
        remaining        <= remaining - CREDIT_W'(2);
      end else if (change_ready && remaining == CREDIT_W'(1)) begin
        return_one_rupee <= 1'b1;
        remaining        <= '0;
      end
    end
  end

  assign done = (remaining == '0);

endmodule

// File: rtl/vending_machine_gen.sv
// Parametrised rupee vending machine: accumulates 1/2/5 rupee coins in a
// binary credit counter, vends at PRICE through a dispense/ack handshake
// with timeout refund, and pays change or refunds through a serial
// hopper-gated payout engine. All outputs come straight from registers.
module vending_machine_gen #(
  parameter int PRICE        = 5,
  parameter int CREDIT_W     = 4,
  parameter int ENABLE_FIVE  = 1,
  parameter int VEND_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rupee_one,
  input  logic                rupee_two,
  input  logic                rupee_five,
  input  logic                cancel,
  input  logic                dispense_ack,
  input  logic                change_ready,
  output logic                dispense,
  output logic                return_one_rupee,
  output logic                return_two_rupee,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [2:0]          state
);
  import vending_pkg::*;

  localparam int                  TIMER_W      = $clog2(VEND_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0]  TIMEOUT_LAST = TIMER_W'(VEND_TIMEOUT - 1);
  localparam logic [CREDIT_W-1:0] PRICE_C      = CREDIT_W'(PRICE);
  localparam logic                FIVE_EN      = (ENABLE_FIVE != 0);

  // The largest reachable credit is PRICE-1+5, which must fit the counter.
  if (PRICE < 1 || VEND_TIMEOUT < 1 || (1 << CREDIT_W) <= PRICE + 4) begin : g_param_check
    $error("vending_machine_gen: PRICE/CREDIT_W/VEND_TIMEOUT out of range");
  end

  logic [2:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                dispense_d, busy_d, coin_reject_d;
  logic                pay_load, pay_done;
  logic [CREDIT_W-1:0] pay_value, pay_remaining;
  logic [CREDIT_W-1:0] sum, diff;
  coin_t               coin;

  assign coin = coin_decode(rupee_one, rupee_two, rupee_five, FIVE_EN);
  assign sum  = credit_q + CREDIT_W'(coin.value);
  assign diff = credit_q - PRICE_C;

  // State, credit, vend timer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      credit_q    <= '0;
      timer_q     <= '0;
      dispense    <= 1'b0;
      busy        <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      timer_q     <= timer_d;
      dispense    <= dispense_d;
      busy        <= busy_d;
      coin_reject <= coin_reject_d;
    end
  end

  // Next state, credit and payout loading.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    credit_d  = credit_q;
    timer_d   = '0;
    pay_load  = 1'b0;
    pay_value = credit_q;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        // The coin is credited first; vend beats cancel.
        if (sum >= PRICE_C) begin
          state_d  = ST_VEND;
          credit_d = sum;
        end else if (cancel && state_q == ST_COLLECT) begin
          state_d   = ST_REFUND;
          credit_d  = '0;
          pay_load  = 1'b1;
          pay_value = sum;
        end else if (sum != '0) begin
          state_d  = ST_COLLECT;
          credit_d = sum;
        end
      end
      ST_VEND: begin
        // Ack wins over a coincident timeout.
        if (dispense_ack) begin
          credit_d = '0;
          if (diff != '0) begin
            state_d   = ST_CHANGE;
            pay_load  = 1'b1;
            pay_value = diff;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d   = ST_REFUND;
          credit_d  = '0;
          pay_load  = 1'b1;
          pay_value = credit_q;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_CHANGE, ST_REFUND: begin
        if (pay_done) state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase
  end

  // Next values of the registered handshake/status outputs.
  always_comb begin
    dispense_d    = (state_d == ST_VEND);
    busy_d        = (state_d inside {ST_VEND, ST_CHANGE, ST_REFUND});
    coin_reject_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_COLLECT:          coin_reject_d = coin.reject;
      ST_VEND, ST_CHANGE, ST_REFUND: coin_reject_d = coin.present;
      default:                      coin_reject_d = 1'b0;
    endcase
  end

  vending_change_payout #(.CREDIT_W(CREDIT_W)) u_payout (
    .clk              (clk),
    .reset            (reset),
    .load             (pay_load),
    .load_value       (pay_value),
    .change_ready     (change_ready),
    .return_one_rupee (return_one_rupee),
    .return_two_rupee (return_two_rupee),
    .remaining        (pay_remaining),
    .done             (pay_done)
  );

  // During payout the engine owns the remaining amount; both sources are registers.
  assign credit = (state_q == ST_CHANGE || state_q == ST_REFUND) ? pay_remaining : credit_q;
  assign state  = state_q;

endmodule

// File: tb/tb_vending_machine_gen.sv
// Directed-vector bench for vending_machine_gen at PRICE=5, CREDIT_W=4.
module tb_vending_machine_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rupee_one = 1'b0, rupee_two = 1'b0, rupee_five = 1'b0;
  logic       cancel = 1'b0, dispense_ack = 1'b0, change_ready = 1'b1;
  logic       dispense, return_one_rupee, return_two_rupee, coin_reject, busy;
  logic [3:0] credit;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;
  int ones = 0, twos = 0, both = 0, disp_cycles = 0;

  vending_machine_gen #(.PRICE(5), .CREDIT_W(4), .ENABLE_FIVE(1), .VEND_TIMEOUT(15)) dut (
    .clk              (clk),
    .reset            (reset),
    .rupee_one        (rupee_one),
    .rupee_two        (rupee_two),
    .rupee_five       (rupee_five),
    .cancel           (cancel),
    .dispense_ack     (dispense_ack),
    .change_ready     (change_ready),
    .dispense         (dispense),
    .return_one_rupee (return_one_rupee),
    .return_two_rupee (return_two_rupee),
    .coin_reject      (coin_reject),
    .busy             (busy),
    .credit           (credit),
    .state            (state)
  );

  always #5 clk = ~clk;

  // Pulse tallies sampled on the falling edge.
  always @(negedge clk) begin
    if (return_one_rupee) ones++;
    if (return_two_rupee) twos++;
    if (return_one_rupee && return_two_rupee) both++;
    if (dispense) disp_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // v: 1, 2, 5 single coins; 3 means rupee_one+rupee_two together.
  task automatic coin(input int v, input logic with_cancel);
    rupee_one  = (v == 1 || v == 3);
    rupee_two  = (v == 2 || v == 3);
    rupee_five = (v == 5);
    cancel     = with_cancel;
    tick();
    rupee_one = 0; rupee_two = 0; rupee_five = 0; cancel = 0;
  endtask

  task automatic ack();
    dispense_ack = 1; tick(); dispense_ack = 0;
  endtask

  int o0, t0, d0, cnt;

  initial begin
    #12 reset = 1'b1;
    #1;
    check("rst_state", state, 0);
    check("rst_credit", credit, 0);
    check("rst_dispense", dispense, 0);
    check("rst_busy", busy, 0);
    check("rst_returns", {return_one_rupee, return_two_rupee, coin_reject}, 0);

    // 1 + 2 + 2 = 5 exact vend
    o0 = ones; t0 = twos;
    coin(1, 0); check("t1_credit1", credit, 1); check("t1_collect", state, 1);
    coin(2, 0); check("t1_credit3", credit, 3);
    coin(2, 0); check("t1_credit5", credit, 5); check("t1_vend", state, 2);
    check("t1_dispense", dispense, 1); check("t1_busy", busy, 1);
    tick();     check("t1_dispense_held", dispense, 1);
    ack();      check("t1_idle", state, 0); check("t1_disp_off", dispense, 0);
    check("t1_credit0", credit, 0);
    tick(); tick();
    check("t1_no_returns", (ones - o0) + (twos - t0), 0);

    // 2 + 2 + 5 = 9, change 4 as two 2-rupee coins
    o0 = ones; t0 = twos;
    coin(2, 0); coin(2, 0); check("t2_credit4", credit, 4);
    coin(5, 0); check("t2_credit9", credit, 9); check("t2_vend", state, 2);
    ack();      check("t2_change", state, 3); check("t2_change_credit", credit, 4);
    check("t2_busy", busy, 1);
    tick();     check("t2_two_a", return_two_rupee, 1); check("t2_credit2", credit, 2);
    tick();     check("t2_two_b", return_two_rupee, 1); check("t2_credit0", credit, 0);
    tick();     check("t2_idle", state, 0); check("t2_busy_off", busy, 0);
    check("t2_twos", twos - t0, 2); check("t2_ones", ones - o0, 0);

    // credit 3, hopper stalled, cancel -> refund 2 then 1
    o0 = ones; t0 = twos; d0 = disp_cycles;
    coin(1, 0); coin(2, 0); check("t3_credit3", credit, 3);
    change_ready = 0;
    coin(0, 1); check("t3_refund", state, 4); check("t3_refund_credit", credit, 3);
    tick(); tick(); tick();
    check("t3_stall_credit", credit, 3); check("t3_stall_pulses", (ones - o0) + (twos - t0), 0);
    change_ready = 1;
    tick();     check("t3_two", return_two_rupee, 1); check("t3_credit1", credit, 1);
    tick();     check("t3_one", {return_two_rupee, return_one_rupee}, 1); check("t3_credit0", credit, 0);
    tick();     check("t3_idle", state, 0);
    check("t3_no_dispense", disp_cycles - d0, 0);

    // credit 6 in VEND, coin rejected, timeout after 15 cycles, refund 2+2+2
    o0 = ones; t0 = twos;
    coin(1, 0); coin(5, 0); check("t4_vend", state, 2); check("t4_credit6", credit, 6);
    cnt = 1;
    coin(2, 0); check("t4_vend_reject", coin_reject, 1); check("t4_vend_credit", credit, 6);
    if (state == 3'd2) cnt++;
    for (int i = 0; i < 30; i++) begin
      if (state != 3'd2) break;
      tick();
      if (state == 3'd2) cnt++;
    end
    check("t4_vend_cycles", cnt, 15);
    check("t4_refund", state, 4); check("t4_disp_off", dispense, 0);
    check("t4_refund_credit", credit, 6);
    tick(); tick(); tick();
    check("t4_refund_done", credit, 0);
    tick();     check("t4_idle", state, 0);
    check("t4_twos", twos - t0, 3); check("t4_ones", ones - o0, 0);

    // simultaneous coins rejected; cancel ignored in IDLE; cancel+coin paths
    coin(0, 1); check("t5_idle_cancel", state, 0);
    coin(2, 0); check("t5_credit2", credit, 2);
    coin(3, 0); check("t5_multi_reject", coin_reject, 1); check("t5_multi_credit", credit, 2);
    check("t5_collect", state, 1);
    tick();     check("t5_reject_pulse", coin_reject, 0);
    coin(1, 1); check("t5_cancel_coin", state, 4); check("t5_cancel_credit", credit, 3);
    tick(); tick(); tick(); check("t5_idle", state, 0);
    coin(2, 0); coin(2, 0);
    coin(1, 1); check("t5_vend_wins", state, 2); check("t5_vend_credit", credit, 5);
    ack();      check("t5_idle2", state, 0);

    // reset asserted mid-CHANGE with 3 remaining
    coin(1, 0); coin(2, 0); coin(5, 0); check("t6_credit8", credit, 8);
    change_ready = 0;
    ack();      check("t6_change", state, 3); check("t6_change_credit", credit, 3);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_state", state, 0); check("t6_rst_credit", credit, 0);
    check("t6_rst_outs", {dispense, return_one_rupee, return_two_rupee, coin_reject, busy}, 0);
    #2 reset = 1'b1;
    change_ready = 1;
    o0 = ones; t0 = twos;
    tick(); tick(); tick();
    check("t6_no_pulses", (ones - o0) + (twos - t0), 0);
    check("t6_idle", state, 0);

    check("never_both_pulses", both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
